// File: rtl/bus_rx_fifo_pkg.sv
// Shared definitions for the bus receive stage: destination field layout,
// broadcast address and a helper that pulls the destination out of a word.
package bus_rx_fifo_pkg;

   localparam int unsigned ID_W  = 8;
   localparam int unsigned MAX_W = 256;
   localparam logic [ID_W-1:0] BCAST = 8'hFF;

   // Packet layout for the default 16-bit bus.
   localparam int unsigned DEF_W = 16;
   typedef struct packed {
      logic [ID_W-1:0]       dest;
      logic [DEF_W-ID_W-1:0] payload;
   } pkt_t;

   // Destination always sits in the top ID_W bits, whatever the bus width.
   function automatic logic [ID_W-1:0] get_dest(input logic [MAX_W-1:0] data,
                                                input int unsigned       w);
      return data[w-1 -: ID_W];
   endfunction

endpackage

// File: rtl/bus_rx_fifo_core.sv
// Pointer/count FIFO with first-word-fall-through output; dout reads 0 when empty.
module bus_rx_fifo_core #(
   parameter int unsigned W     = 16,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned CW   = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          empty,
   output logic          full,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          wr, rd;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;
   assign dout  = empty ? '0 : mem_q[rd_ptr_q];

   // A pop on a full FIFO frees the slot the concurrent push lands in.
   assign wr = push && (!full || pop);
   assign rd = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (rd) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr, rd})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/bus_rx_fifo.sv
// Per-device receive stage: filters bus words by destination ID / broadcast,
// buffers them, and tracks drops (overflow, drop_cnt) and empty pops (underflow).
module bus_rx_fifo
   import bus_rx_fifo_pkg::*;
#(
   parameter int unsigned     width   = 16,
   parameter int unsigned     depth   = 8,
   parameter int unsigned     devices = 4,
   parameter int unsigned     id      = 0,
   parameter logic [ID_W-1:0] bcast   = BCAST,
   localparam int unsigned    CW      = $clog2(depth) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bus_push,
   input  logic [width-1:0] bus_data,
   input  logic             pop,
   output logic [width-1:0] dout,
   output logic             pndng,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             overflow,
   output logic [7:0]       drop_cnt,
   output logic             underflow,
   input  logic             clr_ovf
);

   // An out-of-range id never claims unicast traffic; broadcast still lands.
   localparam bit ID_OK = (id < devices);

   logic [ID_W-1:0] dest;
   logic            match, drop, empty;
   logic            overflow_q, overflow_d;
   logic [7:0]      drop_cnt_q, drop_cnt_d;
   logic            underflow_q, underflow_d;

   assign dest  = get_dest(MAX_W'(bus_data), width);
   assign match = bus_push && ((ID_OK && dest == ID_W'(id)) || dest == bcast);
   assign drop  = match && full && !pop;

   bus_rx_fifo_core #(.W(width), .DEPTH(depth)) u_core (
      .clk   (clk),
      .reset (reset),
      .push  (match),
      .pop   (pop),
      .din   (bus_data),
      .dout  (dout),
      .empty (empty),
      .full  (full),
      .count (count)
   );

   assign pndng = !empty;

   // A drop in the same cycle as clr_ovf wins: the new drop is the first counted.
   always_comb begin
      overflow_d  = overflow_q;
      drop_cnt_d  = drop_cnt_q;
      underflow_d = pop && empty;
      if (drop) begin
         overflow_d = 1'b1;
         if (clr_ovf)                 drop_cnt_d = 8'd1;
         else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end else if (clr_ovf) begin
         overflow_d = 1'b0;
         drop_cnt_d = 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         overflow_q  <= 1'b0;
         drop_cnt_q  <= 8'd0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         drop_cnt_q  <= drop_cnt_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_bus_rx_fifo.sv
// Directed plus random stimulus for bus_rx_fifo (id=2) against a queue-based model.
module tb_bus_rx_fifo;

   localparam int W = 16;
   localparam int D = 8;
   localparam int ID = 2;

   logic         clk = 1'b0;
   logic         reset;
   logic         bus_push;
   logic [W-1:0] bus_data;
   logic         pop;
   logic [W-1:0] dout;
   logic         pndng;
   logic [3:0]   count;
   logic         full;
   logic         overflow;
   logic [7:0]   drop_cnt;
   logic         underflow;
   logic         clr_ovf;

   int checks = 0;
   int errors = 0;

   // reference state
   logic [W-1:0] q[$];
   bit           m_ovf;
   int           m_drops;
   bit           m_und;

   always #5 clk = ~clk;

   bus_rx_fifo #(.width(W), .depth(D), .devices(4), .id(ID), .bcast(8'hFF)) dut (
      .clk(clk), .reset(reset), .bus_push(bus_push), .bus_data(bus_data),
      .pop(pop), .dout(dout), .pndng(pndng), .count(count), .full(full),
      .overflow(overflow), .drop_cnt(drop_cnt), .underflow(underflow),
      .clr_ovf(clr_ovf)
   );

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit rst, input bit p, input logic [W-1:0] d,
                             input bit pp, input bit clr);
      bit matched, was_full, dropped;
      if (!rst) begin
         q.delete(); m_ovf = 0; m_drops = 0; m_und = 0;
         return;
      end
      matched  = p && (d[15:8] == 8'(ID) || d[15:8] == 8'hFF);
      was_full = (q.size() == D);
      dropped  = matched && was_full && !pp;
      m_und    = pp && q.size() == 0;
      if (pp && q.size() > 0) void'(q.pop_front());
      if (matched && !dropped) q.push_back(d);
      if (dropped) begin
         m_ovf   = 1;
         m_drops = clr ? 1 : (m_drops < 255 ? m_drops + 1 : 255);
      end else if (clr) begin
         m_ovf = 0; m_drops = 0;
      end
   endtask

   task automatic check_all(input string tag);
      cmp({tag, ".count"}, 32'(count), 32'(q.size()));
      cmp({tag, ".pndng"}, 32'(pndng), 32'(q.size() != 0));
      cmp({tag, ".full"}, 32'(full), 32'(q.size() == D));
      cmp({tag, ".dout"}, 32'(dout), q.size() != 0 ? 32'(q[0]) : 32'h0);
      cmp({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
      cmp({tag, ".drops"}, 32'(drop_cnt), 32'(m_drops));
      cmp({tag, ".und"}, 32'(underflow), 32'(m_und));
   endtask

   task automatic step(input string tag, input bit p, input logic [W-1:0] d,
                       input bit pp, input bit clr, input bit rst = 1'b1);
      reset = rst; bus_push = p; bus_data = d; pop = pp; clr_ovf = clr;
      @(posedge clk);
      model_edge(rst, p, d, pp, clr);
      #1;
      check_all(tag);
   endtask

   logic [W-1:0] popped;
   logic [7:0]   dsel;

   initial begin
      reset = 0; bus_push = 0; bus_data = '0; pop = 0; clr_ovf = 0;
      step("reset", 0, '0, 0, 0, 0);
      cmp("reset.dout0", 32'(dout), 32'h0);

      // reset mid-fill
      for (int i = 0; i < 3; i++) step("fill3", 1, 16'h0250 + 16'(i), 0, 0);
      cmp("fill3.count", 32'(count), 32'd3);
      step("midrst", 1, 16'h0260, 0, 0, 0);
      cmp("midrst.count", 32'(count), 32'd0);
      step("after_rst", 1, 16'h0261, 0, 0);
      cmp("after_rst.dout", 32'(dout), 32'h0261);
      step("drain1", 0, '0, 1, 0);

      // filtering
      step("flt0", 1, 16'h0211, 0, 0);
      step("flt1", 1, 16'h0122, 0, 0);
      step("flt2", 1, 16'hFF33, 0, 0);
      step("flt3", 1, 16'h0344, 0, 0);
      cmp("flt.count", 32'(count), 32'd2);
      cmp("flt.head", 32'(dout), 32'h0211);
      step("flt_pop0", 0, '0, 1, 0);
      cmp("flt.second", 32'(dout), 32'hFF33);
      step("flt_pop1", 0, '0, 1, 0);
      cmp("flt.pndng", 32'(pndng), 32'd0);

      // fill and overflow
      for (int i = 0; i < 10; i++) step("ovf_fill", 1, 16'h0200 + 16'(i), 0, 0);
      cmp("ovf.full", 32'(full), 32'd1);
      cmp("ovf.drops", 32'(drop_cnt), 32'd2);
      // full with simultaneous push and pop
      step("full_pp", 1, 16'h02AA, 1, 0);
      cmp("full_pp.count", 32'(count), 32'd8);
      cmp("full_pp.ovf", 32'(overflow), 32'd1);
      for (int i = 1; i < 9; i++) begin
         popped = dout;
         cmp("drain.order", 32'(popped), i < 8 ? 32'h0200 + 32'(i) : 32'h02AA);
         step("drain", 0, '0, 1, 0);
      end
      cmp("drain.empty", 32'(pndng), 32'd0);

      // underflow and wrap
      step("und", 0, '0, 1, 0);
      cmp("und.pulse", 32'(underflow), 32'd1);
      step("und_off", 0, '0, 0, 0);
      cmp("und.once", 32'(underflow), 32'd0);
      for (int i = 0; i < 20; i++) begin
         step("stream", 1, 16'h0200 + 16'(i), i != 0, 0);
         cmp("stream.le2", 32'(count <= 4'd2), 32'd1);
      end
      step("stream_end", 0, '0, 1, 0);

      // clr_ovf race
      step("clr_pre", 0, '0, 0, 1);
      for (int i = 0; i < 13; i++) step("race_fill", 1, 16'hFF00 + 16'(i), 0, 0);
      cmp("race.drops5", 32'(drop_cnt), 32'd5);
      step("race", 1, 16'h02EE, 0, 1);
      cmp("race.ovf", 32'(overflow), 32'd1);
      cmp("race.drops", 32'(drop_cnt), 32'd1);
      step("clr_only", 0, '0, 0, 1);
      cmp("clr.ovf", 32'(overflow), 32'd0);
      cmp("clr.drops", 32'(drop_cnt), 32'd0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 4))
            0: dsel = 8'h00;
            1: dsel = 8'h01;
            2: dsel = 8'h03;
            3: dsel = 8'hFF;
            default: dsel = 8'(ID);
         endcase
         step("rand", $urandom_range(0, 3) != 0, {dsel, 8'($urandom)},
              $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 99) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
